// File: rtl/micro_waves_control_p.sv
// Microwave oven controller: BCD keypad entry, 1 s countdown, duty-cycled magnetron.
// Latency: state/digits update one clk after the causing input; mag_on/done follow registered state.
// Backpressure: none; level inputs are sampled every cycle, keys are edge-detected.
module micro_waves_control_p #(
   parameter int TICK_DIV   = 100,
   parameter int MIN_DIGITS = 1,
   parameter int PWR_PERIOD = 10
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    startn,
   input  logic                    stopn,
   input  logic                    clearn,
   input  logic                    door_closed,
   input  logic [9:0]              keypad,
   input  logic [3:0]              power,
   output logic [3:0]              unidades,
   output logic [3:0]              dezenas,
   output logic [4*MIN_DIGITS-1:0] minutos,
   output logic                    mag_on,
   output logic                    done,
   output logic [1:0]              state
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COOK  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int             MW        = 4 * MIN_DIGITS;
   localparam int             PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [3:0]     PWR_LEN   = 4'(PWR_PERIOD);
   localparam logic [3:0]     PWR_MAX   = 4'(PWR_PERIOD - 1);

   state_e          state_q, state_d;
   logic [3:0]      uni_q, uni_d;
   logic [3:0]      dez_q, dez_d;
   logic [MW-1:0]   min_q, min_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [3:0]      pwr_q, pwr_d;
   logic [9:0]      key_prev_q, key_prev_d;

   logic            key_press;
   logic [3:0]      key_val;
   logic            time_zero;
   logic            hold_req;
   logic            start_req;
   logic [MW-1:0]   min_dec;
   logic            borrow;
   logic [3:0]      eff;

   // Key index of the (one-hot) keypad; a press is a one-hot pattern following an all-zero cycle
   always_comb begin
      key_val = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (keypad[i]) key_val = 4'(i);
      end
   end

   assign key_press = $onehot(keypad) && (key_prev_q == 10'd0);
   assign time_zero = (uni_q == 4'd0) && (dez_q == 4'd0) && (min_q == '0);
   assign hold_req  = !stopn || !door_closed;
   assign start_req = !startn && stopn && door_closed && clearn && !time_zero;

   // Minutes decremented as a multi-digit BCD number (only used when minutes are nonzero)
   always_comb begin
      min_dec = min_q;
      borrow  = 1'b1;
      for (int i = 0; i < MIN_DIGITS; i++) begin
         if (borrow) begin
            if (min_q[4*i +: 4] == 4'd0) begin
               min_dec[4*i +: 4] = 4'd9;
            end else begin
               min_dec[4*i +: 4] = min_q[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   // Next-state, digit entry, countdown and counter updates
   always_comb begin
      state_d    = state_q;
      uni_d      = uni_q;
      dez_d      = dez_q;
      min_d      = min_q;
      presc_d    = presc_q;
      pwr_d      = pwr_q;
      key_prev_d = keypad;

      if (!clearn) begin
         state_d = ST_IDLE;
         uni_d   = 4'd0;
         dez_d   = 4'd0;
         min_d   = '0;
         presc_d = '0;
         pwr_d   = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE, ST_PAUSE: begin
               if (hold_req) begin
                  state_d = state_q;
               end else if (start_req) begin
                  state_d = ST_COOK;
                  // A fresh cook starts a full second and a new power cycle; resume keeps both
                  if (state_q == ST_IDLE) begin
                     presc_d = '0;
                     pwr_d   = 4'd0;
                  end
               end else if (startn && key_press) begin
                  min_d = MW'({min_q, dez_q});
                  dez_d = uni_q;
                  uni_d = key_val;
               end
            end
            ST_COOK: begin
               if (hold_req) begin
                  state_d = ST_PAUSE;
               end else if (time_zero) begin
                  state_d = ST_DONE;
               end else if (presc_q == PRESC_MAX) begin
                  presc_d = '0;
                  pwr_d   = (pwr_q == PWR_MAX) ? 4'd0 : pwr_q + 4'd1;
                  if (uni_q != 4'd0) begin
                     uni_d = uni_q - 4'd1;
                  end else begin
                     uni_d = 4'd9;
                     if (dez_q != 4'd0) begin
                        dez_d = dez_q - 4'd1;
                     end else begin
                        dez_d = 4'd5;
                        min_d = min_dec;
                     end
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            default: begin
               if (!door_closed) begin
                  state_d = ST_IDLE;
                  uni_d   = 4'd0;
                  dez_d   = 4'd0;
                  min_d   = '0;
                  presc_d = '0;
                  pwr_d   = 4'd0;
               end
            end
         endcase
      end
   end

   // State registers, cleared immediately by resetn
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         uni_q      <= 4'd0;
         dez_q      <= 4'd0;
         min_q      <= '0;
         presc_q    <= '0;
         pwr_q      <= 4'd0;
         key_prev_q <= 10'd0;
      end else begin
         state_q    <= state_d;
         uni_q      <= uni_d;
         dez_q      <= dez_d;
         min_q      <= min_d;
         presc_q    <= presc_d;
         pwr_q      <= pwr_d;
         key_prev_q <= key_prev_d;
      end
   end

   // Power 0 or out of range means full power
   always_comb begin
      eff = ((power == 4'd0) || (power >= PWR_LEN)) ? PWR_LEN : power;
   end

   assign mag_on   = (state_q == ST_COOK) && door_closed && (pwr_q < eff);
   assign done     = (state_q == ST_DONE);
   assign state    = state_q;
   assign unidades = uni_q;
   assign dezenas  = dez_q;
   assign minutos  = min_q;

endmodule

// File: tb/tb_micro_waves_control_p.sv
// Self-checking bench for micro_waves_control_p: directed scenarios plus randomized inputs.
// Outputs checked every falling edge against a decimal-arithmetic model of the oven.
// Inputs are driven 2 time units after a rising edge (or 1 after a falling-edge check).
module tb_micro_waves_control_p;
   localparam int TD    = 4;
   localparam int MIN_D = 1;
   localparam int PWR_P = 10;
   localparam int MINMOD = 10 ** MIN_D;

   logic                clk = 1'b0;
   logic                resetn, startn, stopn, clearn, door_closed;
   logic [9:0]          keypad;
   logic [3:0]          power;
   logic [3:0]          unidades, dezenas;
   logic [4*MIN_D-1:0]  minutos;
   logic                mag_on, done;
   logic [1:0]          state;

   int n_checks = 0;
   int n_err    = 0;

   micro_waves_control_p #(.TICK_DIV(TD), .MIN_DIGITS(MIN_D), .PWR_PERIOD(PWR_P)) dut (
      .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
      .door_closed(door_closed), .keypad(keypad), .power(power),
      .unidades(unidades), .dezenas(dezenas), .minutos(minutos),
      .mag_on(mag_on), .done(done), .state(state)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model: time kept as seconds digits + integer minutes
   int         m_state = 0;   // 0 idle, 1 cook, 2 pause, 3 done
   int         m_u = 0, m_d = 0, m_min = 0;
   int         m_cyc = 0;     // cook cycles elapsed in the current second
   int         m_ticks = 0;   // ticks elapsed in the current power period
   logic [9:0] m_prev = '0;

   task automatic model_zero();
      m_u = 0; m_d = 0; m_min = 0; m_cyc = 0; m_ticks = 0;
   endtask

   task automatic model_reset();
      model_zero();
      m_state = 0;
      m_prev  = '0;
   endtask

   task automatic model_step();
      bit press, hold, tz;
      int kv;
      press = ($countones(keypad) == 1) && (m_prev == 10'd0);
      kv = 0;
      for (int i = 0; i < 10; i++) if (keypad[i]) kv = i;
      m_prev = keypad;
      hold = !stopn || !door_closed;
      tz = (m_u == 0) && (m_d == 0) && (m_min == 0);
      if (!clearn) begin
         model_zero();
         m_state = 0;
      end else if (m_state == 0 || m_state == 2) begin
         if (!hold) begin
            if (!startn && !tz) begin
               if (m_state == 0) begin m_cyc = 0; m_ticks = 0; end
               m_state = 1;
            end else if (startn && press) begin
               m_min = (m_min * 10 + m_d) % MINMOD;
               m_d = m_u;
               m_u = kv;
            end
         end
      end else if (m_state == 1) begin
         if (hold) m_state = 2;
         else if (tz) m_state = 3;
         else begin
            m_cyc = m_cyc + 1;
            if (m_cyc == TD) begin
               m_cyc = 0;
               m_ticks = (m_ticks + 1) % PWR_P;
               if (m_u > 0) m_u = m_u - 1;
               else if (m_d > 0) begin m_d = m_d - 1; m_u = 9; end
               else begin m_min = m_min - 1; m_d = 5; m_u = 9; end
            end
         end
      end else begin
         if (!door_closed) begin model_zero(); m_state = 0; end
      end
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) model_reset();
      else model_step();
   end

   function automatic logic [31:0] model_min_bcd();
      logic [31:0] r;
      int v;
      r = '0;
      v = m_min;
      for (int i = 0; i < MIN_D; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] model_mag();
      int eff;
      eff = (power == 4'd0 || int'(power) >= PWR_P) ? PWR_P : int'(power);
      return {31'd0, (m_state == 1) && door_closed && (m_ticks < eff)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("state",    32'(state),    32'(m_state));
      chk("unidades", 32'(unidades), 32'(m_u));
      chk("dezenas",  32'(dezenas),  32'(m_d));
      chk("minutos",  32'(minutos),  model_min_bcd());
      chk("mag_on",   32'(mag_on),   model_mag());
      chk("done",     32'(done),     32'(m_state == 3));
   end

   // ---------------- stimulus helpers
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic press(input int k);
      keypad = 10'd1 << k;
      cyc(1);
      keypad = '0;
      cyc(1);
   endtask

   task automatic start_pulse();
      startn = 1'b0;
      cyc(1);
      startn = 1'b1;
   endtask

   task automatic clear_pulse();
      clearn = 1'b0;
      cyc(1);
      clearn = 1'b1;
   endtask

   task automatic expect_all(input string tag, input int st, input int mn, input int dz,
                             input int un, input int mg, input int dn);
      @(negedge clk);
      chk({tag, ".state"},    32'(state),    32'(st));
      chk({tag, ".minutos"},  32'(minutos),  32'(mn));
      chk({tag, ".dezenas"},  32'(dezenas),  32'(dz));
      chk({tag, ".unidades"}, 32'(unidades), 32'(un));
      chk({tag, ".mag_on"},   32'(mag_on),   32'(mg));
      chk({tag, ".done"},     32'(done),     32'(dn));
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;
      int r;
      resetn = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
      door_closed = 1'b1; keypad = '0; power = 4'd0;
      #1 resetn = 1'b0;
      expect_all("reset", 0, 0, 0, 0, 0, 0);
      resetn = 1'b1;
      cyc(1);

      // Digit entry, shifting, minute overflow with one minute digit
      press(1); press(3); press(0);
      expect_all("keys130", 0, 1, 3, 0, 0, 0);
      press(5);
      expect_all("keys1305", 0, 3, 0, 5, 0, 0);
      keypad = 10'b0000000011; cyc(1); keypad = '0; cyc(1);
      expect_all("multi_key", 0, 3, 0, 5, 0, 0);
      keypad = 10'd1 << 7; cyc(4); keypad = '0; cyc(1);
      expect_all("held_key", 0, 0, 5, 7, 0, 0);
      clear_pulse();
      expect_all("clear", 0, 0, 0, 0, 0, 0);

      // 0:02 countdown timing
      press(2);
      start_pulse();
      expect_all("start", 1, 0, 0, 2, 1, 0);
      cyc(3);
      expect_all("pre_tick", 1, 0, 0, 2, 1, 0);
      cyc(1);
      expect_all("tick1", 1, 0, 0, 1, 1, 0);
      cyc(4);
      expect_all("tick2", 1, 0, 0, 0, 1, 0);
      cyc(1);
      expect_all("done", 3, 0, 0, 0, 0, 1);
      door_closed = 1'b0; cyc(1); door_closed = 1'b1;
      expect_all("done_exit", 0, 0, 0, 0, 0, 0);

      // Borrow across digits, and unnormalised tens
      press(1); press(0); press(0);
      start_pulse(); cyc(4);
      expect_all("1m_tick", 1, 0, 5, 9, 1, 0);
      clear_pulse();
      press(9); press(9);
      start_pulse(); cyc(4);
      expect_all("t099", 1, 0, 9, 8, 1, 0);
      clear_pulse();

      // Pause mid-second keeps the prescaler
      press(5);
      start_pulse(); cyc(2);
      door_closed = 1'b0; cyc(1);
      expect_all("pause", 2, 0, 0, 5, 0, 0);
      cyc(3);
      door_closed = 1'b1; startn = 1'b0; cyc(1); startn = 1'b1;
      expect_all("resume", 1, 0, 0, 5, 1, 0);
      cyc(1);
      expect_all("resume1", 1, 0, 0, 5, 1, 0);
      cyc(1);
      expect_all("resume2", 1, 0, 0, 4, 1, 0);
      clear_pulse();

      // Power duty cycle: 3 of 10 ticks, then full power
      power = 4'd3;
      press(2); press(0);
      start_pulse();
      cnt = 0;
      repeat (40) begin @(negedge clk); cnt += int'(mag_on); end
      chk("pwr3_window1", 32'(cnt), 32'd12);
      cnt = 0;
      repeat (40) begin @(negedge clk); cnt += int'(mag_on); end
      chk("pwr3_window2", 32'(cnt), 32'd12);
      #1;
      clear_pulse();
      power = 4'd0;
      press(2); press(0);
      start_pulse();
      cnt = 0;
      repeat (40) begin @(negedge clk); cnt += int'(mag_on); end
      chk("pwr0_window", 32'(cnt), 32'd40);
      #1;
      clear_pulse();

      // Asynchronous reset mid-cook, clear beats start, start ignored at 0:00
      press(5);
      start_pulse(); cyc(3);
      resetn = 1'b0;
      #1;
      chk("async_rst.state", 32'(state), 32'd0);
      chk("async_rst.unidades", 32'(unidades), 32'd0);
      chk("async_rst.mag_on", 32'(mag_on), 32'd0);
      cyc(1);
      resetn = 1'b1;
      cyc(1);
      expect_all("post_reset", 0, 0, 0, 0, 0, 0);
      press(3);
      clearn = 1'b0; startn = 1'b0; cyc(1); clearn = 1'b1;
      expect_all("clr_start", 0, 0, 0, 0, 0, 0);
      cyc(3);
      expect_all("start_zero", 0, 0, 0, 0, 0, 0);
      startn = 1'b1;
      cyc(1);

      // Randomized inputs, checked by the per-cycle compare process
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 99);
         if (r < 70) keypad = '0;
         else if (r < 92) keypad = 10'd1 << $urandom_range(0, 9);
         else keypad = 10'($urandom);
         startn      = ($urandom_range(0, 99) < 12) ? 1'b0 : 1'b1;
         stopn       = ($urandom_range(0, 99) < 4)  ? 1'b0 : 1'b1;
         door_closed = ($urandom_range(0, 99) < 5)  ? 1'b0 : 1'b1;
         clearn      = ($urandom_range(0, 199) < 2) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 99) < 2) power = 4'($urandom_range(0, 15));
         cyc(1);
      end
      keypad = '0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; clearn = 1'b1;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/micro_waves_control_p.md
MICRO_WAVES_CONTROL_P -- requirements
Module: micro_waves_control_p

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100: clk cycles per 1 s countdown tick (>=2).
REQ-002 SHALL have parameter MIN_DIGITS, default 1: number of BCD minute digits (1..3).
REQ-003 SHALL have parameter PWR_PERIOD, default 10: power-cycle length in ticks (2..15).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port startn, input, 1: start/resume request, active-low level.
REQ-007 SHALL have port stopn, input, 1: pause request, active-low level.
REQ-008 SHALL have port clearn, input, 1: user clear, active-low level, synchronous.
REQ-009 SHALL have port door_closed, input, 1: 1 = door closed.
REQ-010 SHALL have port keypad, input, 10: one-hot digit keys 0..9.
REQ-011 SHALL have port power, input, 4: magnetron on-ticks per power cycle.
REQ-012 SHALL have port unidades, output, 4: BCD seconds ones.
REQ-013 SHALL have port dezenas, output, 4: BCD seconds tens.
REQ-014 SHALL have port minutos, output, 4*MIN_DIGITS: BCD minutes, most significant digit at top.
REQ-015 SHALL have port mag_on, output, 1: magnetron enable.
REQ-016 SHALL have port done, output, 1: high while in DONE.
REQ-017 SHALL have port state, output, 2: IDLE=0, COOK=1, PAUSE=2, DONE=3.

Function
REQ-018 SHALL run FSM IDLE/COOK/PAUSE/DONE; input priority clearn > (stopn or !door_closed) > startn > keypad.
REQ-019 SHALL detect a key press when keypad is one-hot this cycle and was all-zero the previous cycle; other patterns, and holds, SHALL be ignored.
REQ-020 SHALL, on a key press in IDLE or PAUSE, shift digits left one place (minutes <- minutes<<4 | dezenas, dezenas <- unidades, unidades <- key); top minute digit is discarded.
REQ-021 SHALL ignore key presses in COOK and DONE.
REQ-022 SHALL treat time as zero when every digit is zero; time is zero exactly when its registered digits are zero.
REQ-023 SHALL go IDLE->COOK when startn=0, stopn=1, door_closed=1, clearn=1 and time nonzero; the prescaler and power counter are cleared on this transition.
REQ-024 SHALL ignore startn in IDLE when time is zero, and in COOK and DONE.
REQ-025 SHALL go COOK->PAUSE on stopn=0 or door_closed=0; prescaler and power counter hold their values in PAUSE.
REQ-026 SHALL go PAUSE->COOK under the REQ-023 conditions without clearing the counters.
REQ-027 SHALL, in COOK, increment the prescaler each cycle and assert an internal tick when it equals TICK_DIV-1, wrapping it to 0.
REQ-028 SHALL decrement the time on each tick: unidades-1; if unidades=0 then unidades=9 and dezenas-1; if dezenas also 0 then dezenas=5 and minutes decrement as a BCD number.
REQ-029 SHALL accept entered seconds tens above 5 (e.g. 0:99) and count them down digit by digit without normalisation.
REQ-030 SHALL go COOK->DONE in the cycle after a tick leaves time zero.
REQ-031 SHALL advance the power counter 0..PWR_PERIOD-1, wrapping, on each tick.
REQ-032 SHALL set eff = PWR_PERIOD when power=0 or power>=PWR_PERIOD, else eff = power.
REQ-033 SHALL assert mag_on only when state=COOK, door_closed=1 and power counter < eff; mag_on SHALL be combinational from registered state.
REQ-034 SHALL, on clearn=0 in any state, zero all digits, prescaler and power counter and go IDLE next cycle.
REQ-035 SHALL leave DONE for IDLE on clearn=0 or door_closed=0, with digits zero.

Reset
REQ-036 SHALL, with resetn=0, immediately force state=IDLE, all digits 0, prescaler 0, power counter 0, key-edge register 0, done=0 and mag_on=0, including mid-COOK.
REQ-037 SHALL leave reset synchronously on the first clk edge after resetn rises, with no spurious key press registered.

Verification
REQ-038 Keys 1,3,0 in IDLE -> minutos=1, dezenas=3, unidades=0; with MIN_DIGITS=1, a fourth key 5 -> 3:05.
REQ-039 With TICK_DIV=4, set 0:02, pulse startn -> mag_on=1; 0:01 after 4 cycles; 0:00 after 8; DONE and done=1 on cycle 9; mag_on=0.
REQ-040 Cook 1:00, one tick -> 0:59; set 0:99, one tick -> 0:98.
REQ-041 Cook, then door_closed=0 mid-second -> PAUSE and mag_on=0 with prescaler held; close the door and press startn -> remaining cycles to the next tick are unchanged.
REQ-042 PWR_PERIOD=10, power=3, cook 0:20 -> mag_on high for 3 ticks, low for 7, repeated; power=0 -> mag_on continuously high.
REQ-043 Assert resetn=0 mid-COOK, and clearn with startn asserted together -> IDLE with 0:00 at once; startn with time 0:00 -> stays IDLE.
